// File: rtl/aes_pkg.sv
// Shared AES types, constants and GF(2^8) arithmetic helpers.
package aes_pkg;

  typedef logic [7:0]   byte_t;
  typedef logic [127:0] block_t;

  localparam int unsigned AES_BLOCK_BYTES = 16;

  typedef enum logic [1:0] {
    IDLE,
    SUB,
    DONE
  } inv_sub_state_t;

  // Multiply in GF(2^8) modulo x^8+x^4+x^3+x+1.
  function automatic byte_t gf_mul(input byte_t a, input byte_t b);
    byte_t p;
    byte_t aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

endpackage

// File: rtl/inv_sbox.sv
// Combinational AES inverse S-box. INV_SBOX_GF_EN selects the arithmetic form
// instead of the 256-entry lookup table; both give identical results.
module inv_sbox
  import aes_pkg::*;
(
  input  logic [7:0] data_i,
  output logic [7:0] data_o
);

`ifdef INV_SBOX_GF_EN
  byte_t aff;
  byte_t a2, a4, a8, a16, a32, a64, a128;

  // Inverse affine transform, then x^254 == x^-1 (and 0 -> 0).
  always_comb begin
    aff  = {data_i[6:0], data_i[7]} ^ {data_i[4:0], data_i[7:5]} ^
           {data_i[1:0], data_i[7:2]} ^ 8'h05;
    a2   = gf_mul(aff, aff);
    a4   = gf_mul(a2, a2);
    a8   = gf_mul(a4, a4);
    a16  = gf_mul(a8, a8);
    a32  = gf_mul(a16, a16);
    a64  = gf_mul(a32, a32);
    a128 = gf_mul(a64, a64);
    data_o = gf_mul(gf_mul(gf_mul(a2, a4), gf_mul(a8, a16)),
                    gf_mul(gf_mul(a32, a64), a128));
  end
`else
  localparam byte_t INV_SBOX [256] = '{
    8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38,
    8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
    8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87,
    8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
    8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d,
    8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
    8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2,
    8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
    8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16,
    8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
    8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda,
    8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
    8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a,
    8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
    8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02,
    8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
    8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea,
    8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
    8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85,
    8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
    8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89,
    8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
    8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20,
    8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
    8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31,
    8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
    8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d,
    8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
    8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0,
    8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
    8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26,
    8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
  };

  assign data_o = INV_SBOX[data_i];
`endif

endmodule

// File: rtl/inv_subbyte_iter.sv
// Iterative AES InvSubBytes: substitutes BYTES_PER_CYCLE bytes of a buffered block per clock.
// Inverse S-box implementation is selected by INV_SBOX_GF_EN (see inv_sbox).
module inv_subbyte_iter
  import aes_pkg::*;
#(
  parameter int unsigned BYTES_PER_CYCLE = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy
);

  localparam int unsigned NumChunks = AES_BLOCK_BYTES / BYTES_PER_CYCLE;
  localparam int unsigned CntW      = (NumChunks > 1) ? $clog2(NumChunks) : 1;
  localparam int unsigned ChunkW    = 8 * BYTES_PER_CYCLE;
  localparam int unsigned ChunkSh   = $clog2(ChunkW);

  inv_sub_state_t  state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  block_t          buf_q, buf_d;

  logic [6:0]        base_idx;
  logic [ChunkW-1:0] chunk_in;
  logic [ChunkW-1:0] chunk_out;

  // Bit offset of the current chunk; lowest byte index first.
  assign base_idx = 7'(cnt_q) << ChunkSh;
  assign chunk_in = buf_q[base_idx +: ChunkW];

  for (genvar i = 0; i < BYTES_PER_CYCLE; i++) begin : g_sbox
    inv_sbox u_inv_sbox (
      .data_i (chunk_in[8*i +: 8]),
      .data_o (chunk_out[8*i +: 8])
    );
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    buf_d   = buf_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          buf_d   = in_data;
          cnt_d   = '0;
          state_d = SUB;
        end
      end
      SUB: begin
        buf_d[base_idx +: ChunkW] = chunk_out;
        if (cnt_q == CntW'(NumChunks - 1)) begin
          state_d = DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      buf_q   <= buf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_data  = buf_q;

endmodule

// File: tb/tb_inv_subbyte_iter.sv
// Directed bench for inv_subbyte_iter: main N=4 instance plus N=1,2,8,16 latency instances.
module tb_inv_subbyte_iter;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         busy;

  logic         sw_valid     [4];
  logic         sw_in_ready  [4];
  logic         sw_out_valid [4];
  logic [127:0] sw_out       [4];
  logic         sw_busy      [4];
  logic [127:0] sw_data;

  int n_total;
  int n_bad;

  logic [7:0] fwd_tbl [256];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  inv_subbyte_iter #(.BYTES_PER_CYCLE(4)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy)
  );

  for (genvar g = 0; g < 4; g++) begin : g_sweep
    localparam int unsigned Nb = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
    inv_subbyte_iter #(.BYTES_PER_CYCLE(Nb)) u_sw (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (sw_valid[g]),
      .in_ready  (sw_in_ready[g]),
      .in_data   (sw_data),
      .out_valid (sw_out_valid[g]),
      .out_ready (1'b1),
      .out_data  (sw_out[g]),
      .busy      (sw_busy[g])
    );
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] tb_gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = {aa[6:0], 1'b0} ^ (aa[7] ? 8'h1b : 8'h00);
    end
    return p;
  endfunction

  // Forward S-box built from its definition: inverse by search, then affine map.
  task automatic build_fwd();
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (x != 0 && tb_gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      fwd_tbl[x] = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^
                   {inv[4:0], inv[7:5]} ^ {inv[3:0], inv[7:4]} ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] fwd_block(input logic [127:0] b);
    logic [127:0] r;
    for (int i = 0; i < 16; i++) r[8*i +: 8] = fwd_tbl[b[8*i +: 8]];
    return r;
  endfunction

  // Push one block through the main DUT with out_ready=1; returns result and latency.
  task automatic run_block(input logic [127:0] din, output logic [127:0] dout, output int lat);
    int w;
    w = 0;
    while (!in_ready && w < 50) begin
      tick();
      w++;
    end
    in_data  = din;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    dout = out_data;
    tick();
  endtask

  logic [127:0] res;
  logic [127:0] orig;
  logic [127:0] held;
  logic [127:0] b2b_in  [3];
  logic [127:0] b2b_exp [3];
  logic [127:0] b2b_got [3];
  int           b2b_cyc [3];
  int           lat;
  int           rt_bad;
  int           nout;
  int           k;
  int           cyc;
  logic         acc;
  logic         outh;

  initial begin
    n_total   = 0;
    n_bad     = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    sw_data   = '0;
    for (int g = 0; g < 4; g++) sw_valid[g] = 1'b0;
    build_fwd();

    tick();
    tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 128'h0);
    check("rst_busy", busy, 1'b0);
    rst = 1'b0;
    tick();

    // Directed vectors
    run_block(128'h76abd7fe2b670130c56f6bf27b777c63, res, lat);
    check("single_data", res, 128'h0f0e0d0c0b0a09080706050403020100);
    check("single_lat", 128'(lat), 128'd4);
    run_block({16{8'h63}}, res, lat);
    check("uni_63", res, {16{8'h00}});
    run_block({16{8'h16}}, res, lat);
    check("uni_16", res, {16{8'hff}});
    run_block({16{8'h00}}, res, lat);
    check("uni_00", res, {16{8'h52}});

    // Round trip through the forward S-box model
    rt_bad = 0;
    for (int t = 0; t < 1000; t++) begin
      orig = {$urandom(), $urandom(), $urandom(), $urandom()};
      run_block(fwd_block(orig), res, lat);
      check("roundtrip", res, orig);
    end

    // Latency sweep over the other widths
    for (int g = 0; g < 4; g++) begin
      int nb;
      nb      = (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 8 : 16;
      orig    = 128'h00112233445566778899aabbccddeeff ^ 128'(g);
      sw_data = fwd_block(orig);
      sw_valid[g] = 1'b1;
      tick();
      sw_valid[g] = 1'b0;
      lat = 0;
      while (!sw_out_valid[g] && lat < 64) begin
        tick();
        lat++;
      end
      check("sweep_lat", 128'(lat), 128'(16 / nb));
      check("sweep_data", sw_out[g], orig);
      tick();
      check("sweep_idle", sw_busy[g], 1'b0);
    end

    // Backpressure in DONE
    out_ready = 1'b0;
    in_data   = {16{8'h63}};
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 64) begin
      tick();
      lat++;
    end
    held = out_data;
    check("bp_data", held, 128'h0);
    for (int i = 0; i < 5; i++) begin
      if (i == 1) begin
        in_data  = {16{8'h16}};
        in_valid = 1'b1;
      end
      tick();
      in_valid = 1'b0;
      check("bp_out_valid", out_valid, 1'b1);
      check("bp_stable", out_data, held);
      check("bp_in_ready", in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_release_ready", in_ready, 1'b1);
    check("bp_release_valid", out_valid, 1'b0);
    tick();
    check("bp_no_queue", busy, 1'b0);

    // Reset during the second SUB cycle
    in_data  = 128'h76abd7fe2b670130c56f6bf27b777c63;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", in_ready, 1'b1);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_data", out_data, 128'h0);
    tick();
    rst = 1'b0;
    tick();
    run_block(128'h76abd7fe2b670130c56f6bf27b777c63, res, lat);
    check("post_rst_data", res, 128'h0f0e0d0c0b0a09080706050403020100);
    check("post_rst_lat", 128'(lat), 128'd4);

    // Back-to-back with in_valid held high
    b2b_exp[0] = 128'hdeadbeef0123456789abcdeffedcba98;
    b2b_exp[1] = 128'h0f0e0d0c0b0a09080706050403020100;
    b2b_exp[2] = 128'hffeeddccbbaa99887766554433221100;
    for (int i = 0; i < 3; i++) begin
      b2b_in[i]  = fwd_block(b2b_exp[i]);
      b2b_got[i] = '0;
      b2b_cyc[i] = 0;
    end
    nout     = 0;
    k        = 0;
    cyc      = 0;
    in_data  = b2b_in[0];
    in_valid = 1'b1;
    while (nout < 3 && cyc < 60) begin
      acc  = in_valid && in_ready;
      outh = out_valid && out_ready;
      if (outh) begin
        b2b_got[nout] = out_data;
        b2b_cyc[nout] = cyc;
        nout++;
      end
      tick();
      cyc++;
      if (acc) begin
        k++;
        if (k >= 3) in_valid = 1'b0;
        else in_data = b2b_in[k];
      end
    end
    in_valid = 1'b0;
    check("b2b_count", 128'(nout), 128'd3);
    for (int i = 0; i < 3; i++) check("b2b_data", b2b_got[i], b2b_exp[i]);
    check("b2b_gap01", 128'(b2b_cyc[1] - b2b_cyc[0]), 128'd6);
    check("b2b_gap12", 128'(b2b_cyc[2] - b2b_cyc[1]), 128'd6);
    for (int i = 0; i < 8; i++) begin
      tick();
      check("b2b_no_extra", out_valid, 1'b0);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/inv_subbyte_iter.md
# inv_subbyte_iter

Iterative AES InvSubBytes engine for the decryption datapath. It accepts one 128-bit state over a valid/ready handshake and applies the inverse S-box to BYTES_PER_CYCLE bytes per clock. It returns the substituted state over a second valid/ready handshake. It sits between InvShiftRows and AddRoundKey in the inverse-cipher round and is the decrypt-side counterpart of the combinational forward `subbyte` block.

## Interface
- BYTES_PER_CYCLE, 4, inverse S-box instances and bytes substituted per clock; legal values are 1, 2, 4, 8, 16.
- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  in_data holds a block to be substituted.
- in_ready  out  1  block can accept input; high only in IDLE.
- in_data  in  128  input state; byte i is in_data[8i+7:8i].
- out_valid  out  1  out_data holds a finished block.
- out_ready  in  1  downstream accepts out_data.
- out_data  out  128  substituted state, same byte ordering as in_data.
- busy  out  1  high in SUB or DONE.

## Operation
- Internal storage:
  - 128-bit buffer buf.
  - Chunk counter cnt, sized to hold 0..16/BYTES_PER_CYCLE-1.
  - FSM with states IDLE, SUB, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: buf<=in_data, cnt<=0, go to SUB.
- SUB:
  - Each cycle, bytes cnt*N .. cnt*N+N-1 of buf (N=BYTES_PER_CYCLE) are replaced by inv_sbox(byte). Lowest byte index is processed first.
  - If cnt is the last chunk: go to DONE; otherwise cnt<=cnt+1.
  - in_ready=0, out_valid=0.
- DONE:
  - out_valid=1, out_data=buf.
  - On out_ready: go to IDLE.
- out_data is driven from buf in every state. It is only meaningful while out_valid=1.
- out_data stays stable while out_valid && !out_ready.
- in_valid is ignored outside IDLE; the upstream must hold its data.
- There is no overlap between blocks. A new block is accepted at the earliest one cycle after the out handshake, because the FSM returns to IDLE first.
- Any byte value 0x00..0xFF is valid; there is no error state.

## Timing
- Reset values:
  - state=IDLE, cnt=0, buf=0.
  - in_ready=1, out_valid=0, out_data=0, busy=0.
- Latency: if the input handshake happens on edge E, SUB occupies edges E+1..E+16/N. out_valid rises after edge E+16/N (4 cycles for N=4, 16 for N=1, 1 for N=16).
- Throughput without backpressure: one block every 16/N+2 cycles.
- in_ready and busy are combinational decodes of state only. in_ready never depends on out_ready.
- Reset asserted mid-SUB or in DONE aborts the block. The partial result is discarded and never presented.

## Configuration
- INV_SBOX_GF_EN defined:
  - inv_sbox computes its result arithmetically: the inverse affine transform, then the multiplicative inverse in GF(2^8) modulo x^8+x^4+x^3+x+1, with 0 mapping to 0.
  - Used for area-constrained targets.
- INV_SBOX_GF_EN undefined:
  - inv_sbox is a 256-entry constant lookup table.
- Both builds are bit-identical and have identical cycle timing. The bench runs both.

## Structure
- Shared package aes_pkg holds:
  - typedef byte_t (logic [7:0]).
  - typedef block_t (logic [127:0]).
  - Constant AES_BLOCK_BYTES=16.
  - Enum inv_sub_state_t (IDLE, SUB, DONE).
- Sub-module inv_sbox: purely combinational, 8-bit in, 8-bit out. It is instantiated BYTES_PER_CYCLE times in a generate loop, with chunk selection through cnt-indexed part-selects of buf.

## Test plan
- Single block: in_data=128'h76abd7fe2b670130c56f6bf27b777c63 -> out_data=128'h0f0e0d0c0b0a09080706050403020100. out_valid rises 4 cycles after acceptance (N=4).
- Uniform blocks:
  - All bytes 0x63 -> all 0x00.
  - All bytes 0x16 -> all 0xff.
  - All bytes 0x00 -> all 0x52.
- Round trip:
  - 1000 random blocks passed through forward `subbyte`, then this block, must return the originals.
  - Sweep BYTES_PER_CYCLE over 1, 2, 4, 8, 16; latency must equal 16/N each time.
- Backpressure:
  - Hold out_ready=0 for 5 cycles in DONE -> out_valid stays 1, out_data is unchanged, in_ready=0, and an in_valid pulse is ignored.
  - Release out_ready -> in_ready=1 on the next cycle.
- Reset mid-operation: assert rst during the second SUB cycle -> in_ready=1, out_valid=0, out_data=0 immediately. The next block processes correctly.
- Back-to-back: in_valid held high with 3 distinct blocks and out_ready=1 -> exactly 3 correct outputs, one every 6 cycles (N=4).
